// File: rtl/env_vca_if.sv
// Voice-path bundle between the oscillator/control side and the ADSR envelope + VCA.
// ENV_VELOCITY_EN adds the 7-bit velocity input.
interface env_vca_if;
  logic signed [7:0] sample_in;
  logic              gate;
  logic        [7:0] attack_rate;
  logic        [7:0] decay_rate;
  logic        [7:0] sustain_level;
  logic        [7:0] release_rate;
`ifdef ENV_VELOCITY_EN
  logic        [6:0] velocity;
`endif
  logic signed [7:0] sample_out;
  logic        [7:0] env_level;
  logic        [2:0] env_state;
  logic              busy;

  modport master (
    output sample_in, gate, attack_rate, decay_rate, sustain_level, release_rate,
`ifdef ENV_VELOCITY_EN
    output velocity,
`endif
    input  sample_out, env_level, env_state, busy
  );

  modport slave (
    input  sample_in, gate, attack_rate, decay_rate, sustain_level, release_rate,
`ifdef ENV_VELOCITY_EN
    input  velocity,
`endif
    output sample_out, env_level, env_state, busy
  );
endinterface

// File: rtl/env_vca.sv
// ADSR envelope generator driving an 8x8 signed VCA on the oscillator sample stream.
// Define ENV_VELOCITY_EN to scale the envelope gain by the velocity latched at note-on.
module env_vca #(
  parameter int ENV_W = 16,
  parameter int PRESC = 256
) (
  input  logic      clk,
  input  logic      rst_n,
  env_vca_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int              PW      = (PRESC > 2) ? $clog2(PRESC) : 1;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  logic [PW-1:0]    presc_cnt;
  logic             tick;
  logic             gate_q;
  logic             rise;
  logic             fall;
  state_t           state_q, state_d;
  logic [ENV_W-1:0] env_q, env_d;
  logic [ENV_W-1:0] sustain_env;
  logic [ENV_W:0]   att_sum;
  logic [ENV_W:0]   dec_diff;
  logic [ENV_W-1:0] rel_step;
  logic [7:0]       gain;
  logic signed [15:0] prod;
  logic signed [7:0]  scaled;
  logic signed [7:0]  sample_q;

  // Free-running time base; gate activity never disturbs it.
  assign tick = (presc_cnt == PW'(PRESC - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      gate_q    <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      gate_q    <= bus.gate;
    end
  end

  assign rise = bus.gate & ~gate_q;
  assign fall = ~bus.gate & gate_q;

  assign sustain_env = {bus.sustain_level, {(ENV_W-8){1'b0}}};
  assign att_sum     = {1'b0, env_q} + (ENV_W+1)'(bus.attack_rate);
  assign dec_diff    = {1'b0, env_q} - (ENV_W+1)'(bus.decay_rate);
  assign rel_step    = ENV_W'(bus.release_rate);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  // Gate edges win over the tick: the new state is taken and env is left alone.
  // NOTE: defaults first so every path assigns state_d/env_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise) begin
      state_d = ATTACK;
    end else if (fall && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
      state_d = RELEASE;
    end else if (tick) begin
      case (state_q)
        IDLE: env_d = '0;
        ATTACK: begin
          if (att_sum >= {1'b0, ENV_MAX}) begin
            env_d   = ENV_MAX;
            state_d = DECAY;
          end else begin
            env_d = att_sum[ENV_W-1:0];
          end
        end
        DECAY: begin
          // Borrow out of the subtraction means we undershot zero, hence below S too.
          if (dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] <= sustain_env)) begin
            env_d   = sustain_env;
            state_d = SUSTAIN;
          end else begin
            env_d = dec_diff[ENV_W-1:0];
          end
        end
        SUSTAIN: env_d = sustain_env;
        RELEASE: begin
          if (env_q <= rel_step) begin
            env_d   = '0;
            state_d = IDLE;
          end else begin
            env_d = env_q - rel_step;
          end
        end
        default: begin
          env_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.env_level = env_q[ENV_W-1 -: 8];
  assign bus.env_state = state_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef ENV_VELOCITY_EN
  logic [6:0]  vel_q;
  logic [7:0]  vel_p1;
  logic [14:0] vel_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    vel_q <= '0;
    else if (rise) vel_q <= bus.velocity;
  end

  // (vel_q+1)/128 keeps full velocity at unity gain and the result within 0..255.
  assign vel_p1   = {1'b0, vel_q} + 8'd1;
  assign vel_prod = 15'(bus.env_level) * 15'(vel_p1);
  assign gain     = 8'(vel_prod >> 7);
`else
  assign gain = bus.env_level;
`endif

  // Product spans -32640..32385, so 16 signed bits hold it exactly.
  assign prod   = $signed({{8{bus.sample_in[7]}}, bus.sample_in}) * $signed({8'b0, gain});
  assign scaled = 8'(prod >>> 8);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sample_q <= '0;
    else        sample_q <= scaled;
  end

  assign bus.sample_out = sample_q;

endmodule

// File: tb/tb_env_vca.sv
// Directed bench for env_vca (ENV_W=16, PRESC=4); velocity scenario runs when ENV_VELOCITY_EN is defined.
module tb_env_vca;
  localparam int ENV_W = 16;
  localparam int PRESC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  env_vca_if bus ();

  env_vca #(.ENV_W(ENV_W), .PRESC(PRESC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; the DUT ticks on edges where cyc % PRESC == 0.
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at a negedge whose following posedge carries a tick.
  task automatic align_tick();
    @(negedge clk);
    while (cyc % PRESC != PRESC - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.sample_in = '0; bus.gate = 1'b0;
    bus.attack_rate = '0; bus.decay_rate = '0; bus.sustain_level = '0; bus.release_rate = '0;
`ifdef ENV_VELOCITY_EN
    bus.velocity = 7'd127;
`endif
    clk_n(3);
    vectors++;
    if (bus.env_state !== 3'd0 || bus.env_level !== 8'd0 || bus.sample_out !== 8'sd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got st=%0d lvl=%0d out=%0d busy=%b want 0 0 0 0",
               bus.env_state, bus.env_level, bus.sample_out, bus.busy);
    end
    rst_n = 1'b1;
  endtask

  // Rise lands on a tick clk, so 257 further ticks (1028 clk) reach full scale.
  task automatic test_attack();
    bus.attack_rate = 8'hFF; bus.decay_rate = 8'h00; bus.sustain_level = 8'h80; bus.release_rate = 8'h80;
    align_tick();
    bus.gate = 1'b1;
    clk_n(1);
    vectors++;
    if (bus.env_state !== 3'd1 || bus.env_level !== 8'h00 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL attack_start: got st=%0d lvl=%h busy=%b want 1 00 1", bus.env_state, bus.env_level, bus.busy);
    end
    clk_n(64);
    vectors++;
    if (bus.env_level !== 8'h0F) begin
      errors++;
      $display("FAIL attack_16_ticks: got lvl=%h want 0f", bus.env_level);
    end
    clk_n(963);
    vectors++;
    if (bus.env_state !== 3'd1 || bus.env_level !== 8'hFF) begin
      errors++;
      $display("FAIL attack_256_ticks: got st=%0d lvl=%h want 1 ff", bus.env_state, bus.env_level);
    end
    clk_n(1);
    vectors++;
    if (bus.env_state !== 3'd2 || bus.env_level !== 8'hFF) begin
      errors++;
      $display("FAIL attack_257_ticks: got st=%0d lvl=%h want 2 ff", bus.env_state, bus.env_level);
    end
  endtask

  // Envelope parked at 0xFFFF in DECAY (decay_rate 0 holds).
  task automatic test_full_scale();
    bus.sample_in = -8'sd128;
    clk_n(1);
    vectors++;
    if (bus.sample_out !== -8'sd128) begin
      errors++;
      $display("FAIL full_scale_neg: got %0d want -128", bus.sample_out);
    end
    bus.sample_in = 8'sd127;
    clk_n(1);
    vectors++;
    if (bus.sample_out !== 8'sd126) begin
      errors++;
      $display("FAIL full_scale_pos: got %0d want 126", bus.sample_out);
    end
  endtask

`ifdef ENV_VELOCITY_EN
  task automatic test_velocity();
    bus.release_rate = 8'h00;
    bus.gate = 1'b0;
    clk_n(1);
    bus.velocity = 7'd63;
    bus.gate = 1'b1;
    clk_n(1);
    vectors++;
    if (bus.env_state !== 3'd1 || bus.env_level !== 8'hFF) begin
      errors++;
      $display("FAIL vel_retrigger: got st=%0d lvl=%h want 1 ff", bus.env_state, bus.env_level);
    end
    bus.sample_in = 8'sd100;
    bus.velocity = 7'd127;
    clk_n(1);
    vectors++;
    if (bus.sample_out !== 8'sd49) begin
      errors++;
      $display("FAIL vel_scaled: got %0d want 49", bus.sample_out);
    end
    bus.gate = 1'b0;
    clk_n(1);
    bus.gate = 1'b1;
    clk_n(8);
    vectors++;
    if (bus.env_state !== 3'd2 || bus.env_level !== 8'hFF) begin
      errors++;
      $display("FAIL vel_restore: got st=%0d lvl=%h want 2 ff", bus.env_state, bus.env_level);
    end
  endtask
`endif

  // 0xFFFF down by 0x40 per tick: 512th tick lands on S=0x8000.
  task automatic test_sustain();
    align_tick();
    bus.decay_rate = 8'h40;
    clk_n(2044);
    vectors++;
    if (bus.env_state !== 3'd2 || bus.env_level !== 8'h80) begin
      errors++;
      $display("FAIL decay_511_ticks: got st=%0d lvl=%h want 2 80", bus.env_state, bus.env_level);
    end
    clk_n(1);
    vectors++;
    if (bus.env_state !== 3'd3 || bus.env_level !== 8'h80) begin
      errors++;
      $display("FAIL sustain_reached: got st=%0d lvl=%h want 3 80", bus.env_state, bus.env_level);
    end
    bus.sample_in = 8'sd100;
    clk_n(1);
    vectors++;
    if (bus.sample_out !== 8'sd50) begin
      errors++;
      $display("FAIL sustain_vca_pos: got %0d want 50", bus.sample_out);
    end
    bus.sample_in = -8'sd128;
    clk_n(1);
    vectors++;
    if (bus.sample_out !== -8'sd64) begin
      errors++;
      $display("FAIL sustain_vca_neg: got %0d want -64", bus.sample_out);
    end
    align_tick();
    bus.sustain_level = 8'h60;
    clk_n(1);
    vectors++;
    if (bus.env_state !== 3'd3 || bus.env_level !== 8'h60) begin
      errors++;
      $display("FAIL sustain_track: got st=%0d lvl=%h want 3 60", bus.env_state, bus.env_level);
    end
    bus.sustain_level = 8'h80;
    clk_n(4);
  endtask

  // 0x8000 down by 0x80 per tick: 256 ticks to IDLE.
  task automatic test_release();
    bus.release_rate = 8'h80;
    align_tick();
    bus.gate = 1'b0;
    clk_n(1);
    vectors++;
    if (bus.env_state !== 3'd4 || bus.env_level !== 8'h80) begin
      errors++;
      $display("FAIL release_enter: got st=%0d lvl=%h want 4 80", bus.env_state, bus.env_level);
    end
    clk_n(512);
    vectors++;
    if (bus.env_state !== 3'd4 || bus.env_level !== 8'h40) begin
      errors++;
      $display("FAIL release_128_ticks: got st=%0d lvl=%h want 4 40", bus.env_state, bus.env_level);
    end
    clk_n(511);
    vectors++;
    if (bus.env_state !== 3'd4 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL release_255_ticks: got st=%0d busy=%b want 4 1", bus.env_state, bus.busy);
    end
    clk_n(1);
    vectors++;
    if (bus.env_state !== 3'd0 || bus.busy !== 1'b0 || bus.env_level !== 8'h00) begin
      errors++;
      $display("FAIL release_idle: got st=%0d busy=%b lvl=%h want 0 0 00", bus.env_state, bus.busy, bus.env_level);
    end
    bus.sample_in = 8'sd100;
    clk_n(1);
    vectors++;
    if (bus.sample_out !== 8'sd0) begin
      errors++;
      $display("FAIL idle_silent: got %0d want 0", bus.sample_out);
    end
  endtask

  // Climb to 0x4000, park in RELEASE with rate 0, then retrigger and continue upward.
  task automatic test_retrigger();
    bus.attack_rate = 8'h40;
    bus.release_rate = 8'h00;
    align_tick();
    bus.gate = 1'b1;
    clk_n(1025);
    vectors++;
    if (bus.env_state !== 3'd1 || bus.env_level !== 8'h40) begin
      errors++;
      $display("FAIL retrig_climb: got st=%0d lvl=%h want 1 40", bus.env_state, bus.env_level);
    end
    bus.gate = 1'b0;
    clk_n(9);
    vectors++;
    if (bus.env_state !== 3'd4 || bus.env_level !== 8'h40) begin
      errors++;
      $display("FAIL retrig_hold: got st=%0d lvl=%h want 4 40", bus.env_state, bus.env_level);
    end
    bus.gate = 1'b1;
    bus.sample_in = 8'sd100;
    clk_n(1);
    vectors++;
    if (bus.env_state !== 3'd1 || bus.env_level !== 8'h40) begin
      errors++;
      $display("FAIL retrig_rise: got st=%0d lvl=%h want 1 40", bus.env_state, bus.env_level);
    end
    clk_n(14);
    vectors++;
    if (bus.env_level !== 8'h41 || bus.sample_out !== 8'sd25) begin
      errors++;
      $display("FAIL retrig_resume: got lvl=%h out=%0d want 41 25", bus.env_level, bus.sample_out);
    end
  endtask

  task automatic test_reset_mid_attack();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.env_state !== 3'd0 || bus.env_level !== 8'd0 || bus.sample_out !== 8'sd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got st=%0d lvl=%0d out=%0d busy=%b want 0 0 0 0",
               bus.env_state, bus.env_level, bus.sample_out, bus.busy);
    end
    bus.gate = 1'b0;
    clk_n(2);
    rst_n = 1'b1;
    clk_n(4);
    vectors++;
    if (bus.env_state !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: got st=%0d busy=%b want 0 0", bus.env_state, bus.busy);
    end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_full_scale();
`ifdef ENV_VELOCITY_EN
    test_velocity();
`endif
    test_sustain();
    test_release();
    test_retrigger();
    test_reset_mid_attack();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
